// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the two bus masters and bus_arbiter.
// The arbiter side uses the slave modport; a master-side model uses master.
interface bus_arbiter_if;
  // Handshake: a master holds req high (level) for its whole tenure with a
  // valid slave_id; the arbiter answers with a registered grant one cycle
  // later and the tenure ends on the edge where req is sampled low.
  logic       m1_req;
  logic [1:0] m1_slave_id;
  logic       m2_req;
  logic [1:0] m2_slave_id;
  logic       m1_grant;
  logic       m2_grant;
  logic [1:0] bus_grant;
  logic [1:0] slave_sel;
  logic       timeout;
  logic [1:0] state;

  modport slave (
    input  m1_req, m1_slave_id, m2_req, m2_slave_id,
    output m1_grant, m2_grant, bus_grant, slave_sel, timeout, state
  );

  modport master (
    output m1_req, m1_slave_id, m2_req, m2_slave_id,
    input  m1_grant, m2_grant, bus_grant, slave_sel, timeout, state
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with turnaround cycle and tenure watchdog.
// Define BUS_ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: m1 wins).
module bus_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input logic         clk,
    input logic         rst,
    bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_M1  = 2'd1,
        GNT_M2  = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [1:0]       sel_q, sel_nx;
    logic [1:0]       bus_grant_q;
    logic             m1_grant_q, m2_grant_q, timeout_q;
    logic             lock1_q, lock2_q;
    logic             wd1, wd2;
    logic             elig1, elig2, prefer_m1;

    assign elig1 = bus.m1_req && (bus.m1_slave_id != 2'd0) && !lock1_q;
    assign elig2 = bus.m2_req && (bus.m2_slave_id != 2'd0) && !lock2_q;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    // Set when m1 owned the most recent completed tenure, so m2 wins the next tie.
    logic rr_m2_q;
    assign prefer_m1 = !rr_m2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_m2_q <= 1'b0;
        end else if (state_nx == RELEASE && state_q == GNT_M1) begin
            rr_m2_q <= 1'b1;
        end else if (state_nx == RELEASE && state_q == GNT_M2) begin
            rr_m2_q <= 1'b0;
        end
    end
`else
    assign prefer_m1 = 1'b1;
`endif

    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        sel_nx   = sel_q;
        wd1      = 1'b0;
        wd2      = 1'b0;
        case (state_q)
            IDLE, RELEASE: begin
                cnt_nx   = '0;
                sel_nx   = 2'd0;
                state_nx = IDLE;
                if (elig1 && (prefer_m1 || !elig2)) begin
                    state_nx = GNT_M1;
                    sel_nx   = bus.m1_slave_id;
                end else if (elig2) begin
                    state_nx = GNT_M2;
                    sel_nx   = bus.m2_slave_id;
                end
            end
            GNT_M1: begin
                cnt_nx = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                // A req drop wins over an expiring watchdog on the same edge.
                if (!bus.m1_req) begin
                    state_nx = RELEASE;
                    sel_nx   = 2'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_nx = RELEASE;
                    sel_nx   = 2'd0;
                    wd1      = 1'b1;
                end
            end
            GNT_M2: begin
                cnt_nx = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (!bus.m2_req) begin
                    state_nx = RELEASE;
                    sel_nx   = 2'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_nx = RELEASE;
                    sel_nx   = 2'd0;
                    wd2      = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= 2'd0;
            bus_grant_q <= 2'd0;
            m1_grant_q  <= 1'b0;
            m2_grant_q  <= 1'b0;
            timeout_q   <= 1'b0;
            lock1_q     <= 1'b0;
            lock2_q     <= 1'b0;
        end else begin
            state_q     <= state_nx;
            cnt_q       <= cnt_nx;
            sel_q       <= sel_nx;
            m1_grant_q  <= (state_nx == GNT_M1);
            m2_grant_q  <= (state_nx == GNT_M2);
            bus_grant_q <= {state_nx == GNT_M2, state_nx == GNT_M1};
            timeout_q   <= wd1 | wd2;
            // Lockout holds until the revoked master is seen with req low.
            lock1_q     <= !bus.m1_req ? 1'b0 : (wd1 ? 1'b1 : lock1_q);
            lock2_q     <= !bus.m2_req ? 1'b0 : (wd2 ? 1'b1 : lock2_q);
        end
    end

    assign bus.m1_grant  = m1_grant_q;
    assign bus.m2_grant  = m2_grant_q;
    assign bus.bus_grant = bus_grant_q;
    assign bus.slave_sel = sel_q;
    assign bus.timeout   = timeout_q;
    assign bus.state     = state_q;

endmodule
